// File: rtl/kc_pkg.sv
// Shared types for the keycode event decoder: action encoding, HID keycodes,
// key-to-action map and the event record carried through the FIFO.
package kc_pkg;

  typedef enum logic [1:0] {
    ACT_LEFT   = 2'd0,
    ACT_RIGHT  = 2'd1,
    ACT_JUMP   = 2'd2,
    ACT_ATTACK = 2'd3
  } action_e;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_J     = 8'h0D;

  typedef struct packed {
    logic    valid;
    action_e action;
  } keymap_t;

  typedef struct packed {
    logic    is_press;
    action_e action;
  } evt_t;

  // Unmapped codes (including KC_NONE) return valid=0.
  function automatic keymap_t map_key(input logic [7:0] kc);
    keymap_t m;
    m.valid  = 1'b1;
    m.action = ACT_LEFT;
    case (kc)
      KC_A:     m.action = ACT_LEFT;
      KC_D:     m.action = ACT_RIGHT;
      KC_W:     m.action = ACT_JUMP;
      KC_SPACE: m.action = ACT_JUMP;
      KC_J:     m.action = ACT_ATTACK;
      default:  m.valid  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kc_event_fifo.sv
// Small circular event FIFO with valid/ready read side and a full flag.
// Depth must be a power of two so the pointers wrap by natural overflow.
module kc_event_fifo
  import kc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [2:0] data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output logic [2:0] data_o,
  output logic       full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  evt_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = valid_o ? mem_q[rd_q] : 3'b000;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= evt_t'(data_i);
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the SoC keycode PIO, maps it to game actions and reports held
// levels, per-frame press/release masks and an ordered event stream.
module keycode_event_decoder
  import kc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_vs,
  output logic [3:0] held,
  output logic [3:0] press_frame,
  output logic [3:0] release_frame,
  output logic       frame_tick,
  output logic       evt_valid,
  output logic [2:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_EMIT_REL = 2'd2;
  localparam logic [1:0] ST_EMIT_PRS = 2'd3;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] old_q, old_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] held_q, held_d;
  logic [3:0] pacc_q, pacc_d;
  logic [3:0] racc_q, racc_d;
  logic [3:0] pf_q, pf_d;
  logic [3:0] rf_q, rf_d;
  logic       tick_q;
  logic       vs_q;
  logic       ovf_q, ovf_d;

  keymap_t    m_old, m_new;
  logic [3:0] prs_ev, rel_ev;
  logic       push;
  evt_t       push_ev;
  logic       fifo_full;
  logic       fifo_valid;
  logic       fall;

  assign m_old = map_key(old_q);
  assign m_new = map_key(acc_q);
  assign fall  = vs_q && !frame_vs;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cand_d  = cand_q;
    old_d   = old_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    prs_ev  = 4'b0000;
    rel_ev  = 4'b0000;
    push    = 1'b0;
    push_ev = '0;

    case (state_q)
      ST_IDLE: begin
        if (keycode != acc_q) begin
          state_d = ST_DEBOUNCE;
          cand_d  = keycode;
          cnt_d   = 8'd1;
        end
      end
      ST_DEBOUNCE: begin
        // Bouncing back to the accepted code abandons the candidate silently.
        if (keycode == acc_q) begin
          state_d = ST_IDLE;
        end else if (keycode != cand_q) begin
          cand_d = keycode;
          cnt_d  = 8'd1;
        end else if (cnt_q >= DEB_LAST) begin
          old_d   = acc_q;
          acc_d   = cand_q;
          state_d = ST_EMIT_REL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_EMIT_REL: begin
        if (m_old.valid && !(m_new.valid && (m_new.action == m_old.action))) begin
          push                  = 1'b1;
          push_ev.is_press      = 1'b0;
          push_ev.action        = m_old.action;
          held_d[m_old.action]  = 1'b0;
          rel_ev[m_old.action]  = 1'b1;
        end
        state_d = ST_EMIT_PRS;
      end
      default: begin
        if (m_new.valid && !(m_old.valid && (m_old.action == m_new.action))) begin
          push                  = 1'b1;
          push_ev.is_press      = 1'b1;
          push_ev.action        = m_new.action;
          held_d[m_new.action]  = 1'b1;
          prs_ev[m_new.action]  = 1'b1;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  // Boundary-cycle events land in the freshly cleared accumulators.
  always_comb begin
    pf_d   = pf_q;
    rf_d   = rf_q;
    pacc_d = pacc_q | prs_ev;
    racc_d = racc_q | rel_ev;
    if (fall) begin
      pf_d   = pacc_q;
      rf_d   = racc_q;
      pacc_d = prs_ev;
      racc_d = rel_ev;
    end
    ovf_d = ovf_q | (push && fifo_full && !(evt_ready && fifo_valid));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= KC_NONE;
      cand_q  <= KC_NONE;
      old_q   <= KC_NONE;
      cnt_q   <= 8'd0;
      held_q  <= 4'b0000;
      pacc_q  <= 4'b0000;
      racc_q  <= 4'b0000;
      pf_q    <= 4'b0000;
      rf_q    <= 4'b0000;
      tick_q  <= 1'b0;
      vs_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      old_q   <= old_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pacc_q  <= pacc_d;
      racc_q  <= racc_d;
      pf_q    <= pf_d;
      rf_q    <= rf_d;
      tick_q  <= fall;
      vs_q    <= frame_vs;
      ovf_q   <= ovf_d;
    end
  end

  kc_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push),
    .data_i  (push_ev),
    .pop_i   (evt_ready),
    .valid_o (fifo_valid),
    .data_o  (evt_data),
    .full_o  (fifo_full)
  );

  assign held          = held_q;
  assign press_frame   = pf_q;
  assign release_frame = rf_q;
  assign frame_tick    = tick_q;
  assign evt_valid     = fifo_valid;
  assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Self-checking bench for keycode_event_decoder: vector table plus hand
// sequences, with an expected-event queue compared as the DUT pops events.
module tb_keycode_event_decoder;

  localparam int DC = 16;
  localparam int FD = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_vs;
  logic [3:0] held, press_frame, release_frame;
  logic       frame_tick, evt_valid, evt_ready, evt_overflow;
  logic [2:0] evt_data;

  always #10 Clk = ~Clk;

  keycode_event_decoder #(
    .DEBOUNCE_CYC (DC),
    .FIFO_DEPTH   (FD)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_vs      (frame_vs),
    .held          (held),
    .press_frame   (press_frame),
    .release_frame (release_frame),
    .frame_tick    (frame_tick),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready),
    .evt_overflow  (evt_overflow)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic [7:0] m_acc;
  logic [3:0] m_held, m_pacc, m_racc, m_pf, m_rf;
  logic       m_ovf;

  typedef struct {
    logic [7:0] key;
    int         hold;
    logic [3:0] exp_held;
    bit         do_frame;
  } vec_t;

  vec_t tbl[11];

  // {valid, action index}
  function automatic logic [2:0] tb_map(input logic [7:0] k);
    case (k)
      8'h04:        return 3'b100;
      8'h07:        return 3'b101;
      8'h1A, 8'h2C: return 3'b110;
      8'h0D:        return 3'b111;
      default:      return 3'b000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL evt_unexpected: got %0h, required no event", evt_data);
      end else begin
        chk("evt_head", {29'd0, evt_data}, {29'd0, exp_q.pop_front()});
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic mpush(input logic [2:0] e);
    if (exp_q.size() >= FD) m_ovf = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic model_change(input logic [7:0] nk);
    logic [2:0] o, n;
    o = tb_map(m_acc);
    n = tb_map(nk);
    if (o[2] && !(n[2] && n[1:0] == o[1:0])) begin
      mpush({1'b0, o[1:0]});
      m_held[o[1:0]] = 1'b0;
      m_racc[o[1:0]] = 1'b1;
    end
    if (n[2] && !(o[2] && o[1:0] == n[1:0])) begin
      mpush({1'b1, n[1:0]});
      m_held[n[1:0]] = 1'b1;
      m_pacc[n[1:0]] = 1'b1;
    end
    m_acc = nk;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc  = 8'h00;
    m_held = 4'b0000;
    m_pacc = 4'b0000;
    m_racc = 4'b0000;
    m_pf   = 4'b0000;
    m_rf   = 4'b0000;
    m_ovf  = 1'b0;
  endtask

  task automatic frame();
    frame_vs = 1'b0;
    cyc();
    m_pf   = m_pacc;
    m_rf   = m_racc;
    m_pacc = 4'b0000;
    m_racc = 4'b0000;
    chk("frame_tick", {31'd0, frame_tick}, 32'd1);
    chk("press_frame", {28'd0, press_frame}, {28'd0, m_pf});
    chk("release_frame", {28'd0, release_frame}, {28'd0, m_rf});
    frame_vs = 1'b1;
    cyc();
    chk("frame_tick_off", {31'd0, frame_tick}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{8'h0D, 20, 4'b1000, 1'b1};
    tbl[1]  = '{8'h00, 20, 4'b0000, 1'b0};
    tbl[2]  = '{8'h1A, 20, 4'b0100, 1'b0};
    tbl[3]  = '{8'h2C, 20, 4'b0100, 1'b0};
    tbl[4]  = '{8'h00, 20, 4'b0000, 1'b1};
    tbl[5]  = '{8'h07, 20, 4'b0010, 1'b0};
    tbl[6]  = '{8'h55, 20, 4'b0000, 1'b1};
    tbl[7]  = '{8'h07, 10, 4'b0000, 1'b0};
    tbl[8]  = '{8'h55, 20, 4'b0000, 1'b0};
    tbl[9]  = '{8'h04, 20, 4'b0001, 1'b1};
    tbl[10] = '{8'h00, 20, 4'b0000, 1'b1};

    model_reset();
    Reset     = 1'b1;
    keycode   = 8'h00;
    frame_vs  = 1'b1;
    evt_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_held", {28'd0, held}, 32'd0);
    chk("rst_press_frame", {28'd0, press_frame}, 32'd0);
    chk("rst_release_frame", {28'd0, release_frame}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_evt_data", {29'd0, evt_data}, 32'd0);
    chk("rst_overflow", {31'd0, evt_overflow}, 32'd0);
    Reset = 1'b0;
    repeat (2) cyc();

    // Exact press latency for the first key.
    keycode = 8'h04;
    model_change(8'h04);
    repeat (DC + 1) cyc();
    chk("lat_held_before", {28'd0, held}, 32'd0);
    cyc();
    chk("lat_held_at", {28'd0, held}, 32'h1);
    repeat (4) cyc();
    chk("lat_drained", exp_q.size(), 32'd0);
    frame();

    foreach (tbl[i]) begin
      keycode = tbl[i].key;
      if (tbl[i].hold >= DC + 2) model_change(tbl[i].key);
      repeat (tbl[i].hold) cyc();
      chk($sformatf("tbl%0d_held", i), {28'd0, held}, {28'd0, tbl[i].exp_held});
      chk($sformatf("tbl%0d_held_model", i), {28'd0, held}, {28'd0, m_held});
      chk($sformatf("tbl%0d_drained", i), exp_q.size(), 32'd0);
      if (tbl[i].do_frame) frame();
    end

    // Five events into a four-entry FIFO with the consumer stalled.
    evt_ready = 1'b0;
    keycode = 8'h04; model_change(8'h04); repeat (20) cyc();
    keycode = 8'h07; model_change(8'h07); repeat (20) cyc();
    keycode = 8'h00; model_change(8'h00); repeat (20) cyc();
    chk("ovf_before", {31'd0, evt_overflow}, 32'd0);
    chk("ovf_valid", {31'd0, evt_valid}, 32'd1);
    keycode = 8'h0D; model_change(8'h0D); repeat (20) cyc();
    chk("ovf_set", {31'd0, evt_overflow}, {31'd0, m_ovf});
    chk("ovf_held", {28'd0, held}, 32'h8);
    evt_ready = 1'b1;
    repeat (8) cyc();
    chk("ovf_drained", exp_q.size(), 32'd0);
    chk("ovf_empty", {31'd0, evt_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, evt_overflow}, 32'd1);
    frame();

    // Reset while a new key is still debouncing over a held key.
    keycode = 8'h07; model_change(8'h07); repeat (20) cyc();
    chk("mid_held", {28'd0, held}, 32'h2);
    keycode = 8'h04;
    repeat (5) cyc();
    Reset   = 1'b1;
    keycode = 8'h00;
    cyc();
    model_reset();
    chk("mrst_held", {28'd0, held}, 32'd0);
    chk("mrst_press_frame", {28'd0, press_frame}, 32'd0);
    chk("mrst_release_frame", {28'd0, release_frame}, 32'd0);
    chk("mrst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("mrst_evt_data", {29'd0, evt_data}, 32'd0);
    chk("mrst_overflow", {31'd0, evt_overflow}, 32'd0);
    Reset = 1'b0;
    repeat (25) cyc();
    chk("mrst_held_after", {28'd0, held}, 32'd0);
    chk("mrst_no_event", {31'd0, evt_valid}, 32'd0);

    // Press committed on the very cycle the frame boundary is detected.
    keycode = 8'h04;
    repeat (DC + 1) cyc();
    frame_vs = 1'b0;
    cyc();
    chk("bnd_tick", {31'd0, frame_tick}, 32'd1);
    chk("bnd_press_frame", {28'd0, press_frame}, 32'd0);
    chk("bnd_held", {28'd0, held}, 32'h1);
    model_change(8'h04);
    frame_vs = 1'b1;
    repeat (5) cyc();
    frame();
    chk("bnd_next_press", {28'd0, press_frame}, 32'h1);
    chk("bnd_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
